// File: rtl/div_unit_if.sv
// div_unit_if -- handshake/data bundle between the EX stage and the divider.
//
// Signals:
//   signed_div_i  1 = signed divide (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high by EX until ready_o is seen
//   annul_i       cancel an in-flight division (flush / exception)
//   result_o      {remainder, quotient}; upper half -> HI, lower half -> LO
//   ready_o       result_o valid
//   stallreq_o    EX stall request towards the stall controller
//
// Modports: master = EX stage (requester), slave = divider.
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit -- multi-cycle signed/unsigned divider for the EX stage.
//
// Radix-2 restoring division, one quotient bit per clock, DATA_W iterations.
// Operands are converted to magnitudes on entry and the signs are fixed up on
// the final iteration, so the core loop is purely unsigned.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset (0 = reset asserted)
//   bus   div_unit_if.slave: operands, start/annul, result, ready, stall request
//
// Build option:
//   DIV_BYZERO_FAST_EN  defined   -> a zero divisor takes a one-cycle BYZERO
//                                    path (ready two edges after start).
//                       undefined -> a zero divisor runs the full iteration
//                                    loop and a latched flag overrides the
//                                    result; timing equals a normal divide.
//   Either way the divide-by-zero result is {raw dividend, all ones}.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  localparam int                CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);
  localparam int                WORK_W   = 2 * DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    END  = 2'd2
`ifdef DIV_BYZERO_FAST_EN
    , BYZERO = 2'd3
`endif
  } state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [WORK_W-1:0]     work_reg, work_next;
  logic [DATA_W-1:0]     divisor_reg, divisor_next;
  logic [DATA_W-1:0]     dividend_reg, dividend_next;
  logic                  sign_q_reg, sign_q_next;
  logic                  sign_r_reg, sign_r_next;
  logic [2*DATA_W-1:0]   result_reg, result_next;
  logic                  ready_reg, ready_next;
`ifndef DIV_BYZERO_FAST_EN
  logic                  zero_reg, zero_next;
`endif

  // Datapath helpers
  logic                  sign1, sign2;
  logic [DATA_W-1:0]     op1_mag, op2_mag;
  logic [WORK_W-1:0]     shifted, work_iter;
  logic [DATA_W+1:0]     diff;
  logic [DATA_W-1:0]     quot_fix, rem_fix;

  assign sign1   = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign sign2   = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign op1_mag = sign1 ? -bus.opdata1_i : bus.opdata1_i;
  assign op2_mag = sign2 ? -bus.opdata2_i : bus.opdata2_i;

  // One restoring step: shift, trial-subtract the divisor from the upper
  // 33 bits, keep the difference only when it did not go negative.
  assign shifted   = {work_reg[WORK_W-2:0], 1'b0};
  assign diff      = {1'b0, shifted[WORK_W-1:DATA_W]} - {2'b00, divisor_reg};
  assign work_iter = diff[DATA_W+1] ? shifted
                                    : {diff[DATA_W:0], shifted[DATA_W-1:1], 1'b1};

  // Quotient takes sign1^sign2, remainder follows the dividend's sign.
  assign quot_fix = sign_q_reg ? -work_iter[DATA_W-1:0] : work_iter[DATA_W-1:0];
  assign rem_fix  = sign_r_reg ? -work_iter[2*DATA_W-1:DATA_W]
                               : work_iter[2*DATA_W-1:DATA_W];

  // The top work bit is always zero once a step completes (remainder < divisor);
  // it is never read back, only shifted out.
  logic unused_work_msb;
  assign unused_work_msb = work_reg[WORK_W-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      work_reg     <= '0;
      divisor_reg  <= '0;
      dividend_reg <= '0;
      sign_q_reg   <= 1'b0;
      sign_r_reg   <= 1'b0;
      result_reg   <= '0;
      ready_reg    <= 1'b0;
`ifndef DIV_BYZERO_FAST_EN
      zero_reg     <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      work_reg     <= work_next;
      divisor_reg  <= divisor_next;
      dividend_reg <= dividend_next;
      sign_q_reg   <= sign_q_next;
      sign_r_reg   <= sign_r_next;
      result_reg   <= result_next;
      ready_reg    <= ready_next;
`ifndef DIV_BYZERO_FAST_EN
      zero_reg     <= zero_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    work_next     = work_reg;
    divisor_next  = divisor_reg;
    dividend_next = dividend_reg;
    sign_q_next   = sign_q_reg;
    sign_r_next   = sign_r_reg;
    result_next   = result_reg;
    ready_next    = ready_reg;
`ifndef DIV_BYZERO_FAST_EN
    zero_next     = zero_reg;
`endif

    case (state_reg)
      IDLE: begin
        ready_next  = 1'b0;
        result_next = '0;
        if (bus.start_i && !bus.annul_i) begin
          work_next     = {{(DATA_W + 1){1'b0}}, op1_mag};
          divisor_next  = op2_mag;
          dividend_next = bus.opdata1_i;
          sign_q_next   = sign1 ^ sign2;
          sign_r_next   = sign1;
          cnt_next      = '0;
`ifdef DIV_BYZERO_FAST_EN
          state_next    = (bus.opdata2_i == '0) ? BYZERO : ON;
`else
          zero_next     = (bus.opdata2_i == '0);
          state_next    = ON;
`endif
        end
      end

      ON: begin
        // Losing start is treated exactly like an annul.
        if (!bus.start_i || bus.annul_i) begin
          state_next = IDLE;
        end else begin
          work_next = work_iter;
          cnt_next  = cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            state_next  = END;
            ready_next  = 1'b1;
            result_next = {rem_fix, quot_fix};
`ifndef DIV_BYZERO_FAST_EN
            if (zero_reg) begin
              result_next = {dividend_reg, {DATA_W{1'b1}}};
            end
`endif
          end
        end
      end

`ifdef DIV_BYZERO_FAST_EN
      BYZERO: begin
        if (!bus.start_i || bus.annul_i) begin
          state_next = IDLE;
        end else begin
          state_next  = END;
          ready_next  = 1'b1;
          result_next = {dividend_reg, {DATA_W{1'b1}}};
        end
      end
`endif

      END: begin
        // Annul is ignored here: the result exists, only start release ends it.
        if (!bus.start_i) begin
          state_next  = IDLE;
          ready_next  = 1'b0;
          result_next = '0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.result_o = result_reg;
  assign bus.ready_o  = ready_reg;

  // Stall while a request is being accepted or a division is running; drops in
  // END so EX advances on the ready cycle. Forced low while reset is held.
  assign bus.stallreq_o = rst & (((state_reg == IDLE) & bus.start_i & ~bus.annul_i)
                                 | (state_reg == ON)
`ifdef DIV_BYZERO_FAST_EN
                                 | (state_reg == BYZERO)
`endif
                                 );

endmodule
